delta_decoder: RTL and testbench
================================

// Module: delta_decoder
// PURPOSE
//  Delta-modulation reconstructor: consumes the 2-bit spike stream from the delta encoder and
//  rebuilds a WIDTH-bit estimate by stepping a saturating accumulator up/down.
//  Optional leak returns the estimate toward a baseline after idle periods.
//  Sits at the receive end of the spike link, feeding the sample output / DAC path.
// PARAMETERS
//  WIDTH      4  width of reconstructed value, step and baseline
//  LEAK_W     8  width of the idle/leak cycle counter and leak_period
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       synchronous reset, active low
//  in_valid     in   1       spike is valid this cycle
//  spike        in   2       01 = ON (rise), 10 = OFF (fall), 00 = none, 11 = illegal
//  step         in   WIDTH   magnitude applied per spike (encoder threshold + 1)
//  load         in   1       load baseline into accumulator and baseline register
//  load_value   in   WIDTH   value captured on load
//  leak_period  in   LEAK_W  idle cycles per leak step; 0 disables leak
//  value        out  WIDTH   reconstructed estimate (registered)
//  value_valid  out  1       pulses 1 cycle after each accepted update (spike, load, leak)
//  sat_hi       out  1       value == all-ones, registered with value
//  sat_lo       out  1       value == 0, registered with value
//  err          out  1       sticky; set on in_valid with spike == 11
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): value=0, baseline=0, idle_cnt=0, value_valid=0, sat_hi=0,
//    sat_lo=1, err=0. Reset mid-operation discards any pending update.
//  Latency: spike/load sampled at posedge N, value/value_valid/sat_* updated at posedge N+1.
//  No back-pressure; one spike accepted every cycle with in_valid=1.
//  Priority per cycle: load > valid spike (01/10) > leak step > hold.
//  ON:  value = min(value + step, 2^WIDTH-1); compute in WIDTH+1 bits, clamp.
//  OFF: value = max(value - step, 0); compute in WIDTH+1 bits signed, clamp.
//  step == 0: spike accepted, value unchanged, value_valid still pulses.
//  spike 00 with in_valid: idle cycle, no value_valid. spike 11: treated as 00, err <= 1.
//  err clears only on reset.
//  Leak FSM, states IDLE_COUNT / STEP:
//   - idle_cnt increments on each cycle without an accepted load or ON/OFF spike
//     (in_valid=0, or spike 00/11).
//   - ON/OFF spike or load clears idle_cnt to 0.
//   - leak_period == 0: idle_cnt held at 0, no leak.
//   - idle_cnt == leak_period-1 on an idle cycle: STEP. value moves 1 LSB toward baseline
//     (no move if equal, no value_valid); idle_cnt <= 0.
//   - idle_cnt saturates at 2^LEAK_W-1, never wraps.
//  Simultaneous leak expiry and spike: spike wins, leak step dropped, idle_cnt <= 0.
//  leak_period lowered below idle_cnt: next idle cycle treats idle_cnt >= leak_period-1 as
//    expiry.
//  load: value <= load_value, baseline <= load_value, value_valid pulses.
// STRUCTURE
//  Package delta_pkg: SPIKE_NONE=2'b00, SPIKE_ON=2'b01, SPIKE_OFF=2'b10, SPIKE_BAD=2'b11
//    (shared with the encoder).
//  Sub-module delta_sat_acc: combinational saturating add/sub of WIDTH-bit value ± step.
//  Top: leak counter/FSM, priority mux, output registers.
// TESTING
//  1 Reset: hold rst_n=0 with spikes 01 -> value=0, sat_lo=1, value_valid=0, err=0.
//  2 step=3, four ON spikes from 0 -> 3,6,9,12, value_valid each cycle, 1-cycle latency;
//    two more ON -> 15,15, sat_hi=1.
//  3 value=2, step=5, OFF -> 0, sat_lo=1; spike 11 -> value held, err=1 stays set.
//  4 load 8, then ON step=4 (value 12), leak_period=3, idle -> 11 after 3 idle cycles,
//    stops at 8.
//  5 leak_period=2; ON arrives on the expiry cycle -> ON applied, no leak, idle_cnt restarts.
//  6 rst_n low mid-stream with load=1 -> all outputs at reset values next cycle,
//    baseline=0.

Source files
------------

// File: rtl/delta_pkg.sv
// Shared spike-link definitions used by the delta encoder and decoder.
package delta_pkg;

    typedef logic [1:0] spike_t;

    localparam spike_t SPIKE_NONE = 2'b00;
    localparam spike_t SPIKE_ON   = 2'b01;
    localparam spike_t SPIKE_OFF  = 2'b10;
    localparam spike_t SPIKE_BAD  = 2'b11;

    // True for the two spike codes that move the accumulator.
    function automatic logic is_move(input spike_t code);
        return (code == SPIKE_ON) || (code == SPIKE_OFF);
    endfunction

endpackage

// File: rtl/delta_sat_acc.sv
// Combinational saturating accumulator step: value +/- step, clamped to [0, 2^WIDTH-1].
module delta_sat_acc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] step,
    input  logic             up,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MAX_VALUE = '1;

    // One extra bit holds the carry (add) or the borrow/sign (subtract).
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, value} + {1'b0, step};
    assign diff = {1'b0, value} - {1'b0, step};

    // Clamp on carry out when adding, on a negative difference when subtracting.
    always_comb begin
        if (up) begin
            result = sum[WIDTH] ? MAX_VALUE : sum[WIDTH-1:0];
        end else begin
            result = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/delta_decoder.sv
// Delta-modulation reconstructor: steps a saturating estimate up/down on ON/OFF spikes,
// and optionally leaks it one LSB at a time back toward the last loaded baseline.
module delta_decoder
    import delta_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LEAK_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        spike,
    input  logic [WIDTH-1:0]  step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [LEAK_W-1:0] leak_period,
    output logic [WIDTH-1:0]  value,
    output logic              value_valid,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              err
);

    // Leak FSM: count idle cycles, or take one step toward the baseline.
    localparam logic [0:0] LEAK_IDLE_COUNT = 1'b0;
    localparam logic [0:0] LEAK_STEP       = 1'b1;

    localparam logic [WIDTH-1:0]  MAX_VALUE = '1;
    localparam logic [LEAK_W-1:0] IDLE_MAX  = '1;

    logic [WIDTH-1:0]  baseline;
    logic [LEAK_W-1:0] idle_cnt;

    logic              move_spike;
    logic              bad_spike;
    logic [LEAK_W-1:0] expiry_cnt;
    logic [0:0]        leak_state;
    logic [WIDTH-1:0]  acc_result;

    logic [WIDTH-1:0]  next_value;
    logic [WIDTH-1:0]  next_baseline;
    logic [LEAK_W-1:0] next_idle_cnt;
    logic              next_valid;

    assign move_spike = in_valid && is_move(spike);
    assign bad_spike  = in_valid && (spike == SPIKE_BAD);
    assign expiry_cnt = leak_period - LEAK_W'(1);

    delta_sat_acc #(
        .WIDTH (WIDTH)
    ) u_sat_acc (
        .value  (value),
        .step   (step),
        .up     (spike == SPIKE_ON),
        .result (acc_result)
    );

    // Leak state decode: an idle cycle at (or past, if the period was lowered) expiry steps.
    always_comb begin
        leak_state = LEAK_IDLE_COUNT;
        if (!load && !move_spike && (leak_period != '0) && (idle_cnt >= expiry_cnt)) begin
            leak_state = LEAK_STEP;
        end
    end

    // Priority mux: load > ON/OFF spike > leak step > hold.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        next_value    = value;
        next_baseline = baseline;
        next_idle_cnt = idle_cnt;
        next_valid    = 1'b0;
        if (load) begin
            next_value    = load_value;
            next_baseline = load_value;
            next_idle_cnt = '0;
            next_valid    = 1'b1;
        end else if (move_spike) begin
            next_value    = acc_result;
            next_idle_cnt = '0;
            next_valid    = 1'b1;
        end else if (leak_period == '0) begin
            next_idle_cnt = '0;
        end else if (leak_state == LEAK_STEP) begin
            next_idle_cnt = '0;
            if (value > baseline) begin
                next_value = value - WIDTH'(1);
                next_valid = 1'b1;
            end else if (value < baseline) begin
                next_value = value + WIDTH'(1);
                next_valid = 1'b1;
            end
        end else if (idle_cnt != IDLE_MAX) begin
            next_idle_cnt = idle_cnt + LEAK_W'(1);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (!rst_n) begin
            value       <= '0;
            baseline    <= '0;
            idle_cnt    <= '0;
            value_valid <= 1'b0;
            sat_hi      <= 1'b0;
            sat_lo      <= 1'b1;
            err         <= 1'b0;
        end else begin
            value       <= next_value;
            baseline    <= next_baseline;
            idle_cnt    <= next_idle_cnt;
            value_valid <= next_valid;
            sat_hi      <= (next_value == MAX_VALUE);
            sat_lo      <= (next_value == '0);
            if (bad_spike) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delta_decoder.sv
// Self-checking bench for delta_decoder: directed scenarios plus randomized traffic,
// all compared cycle by cycle against an integer reference model.
module tb_delta_decoder;

    localparam int WIDTH  = 4;
    localparam int LEAK_W = 8;
    localparam int MAXV   = (1 << WIDTH) - 1;
    localparam int IDLE_SAT = (1 << LEAK_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [1:0]        spike = 2'b00;
    logic [WIDTH-1:0]  step = '0;
    logic              load = 1'b0;
    logic [WIDTH-1:0]  load_value = '0;
    logic [LEAK_W-1:0] leak_period = '0;
    logic [WIDTH-1:0]  value;
    logic              value_valid;
    logic              sat_hi;
    logic              sat_lo;
    logic              err;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_value = 0;
    int m_base  = 0;
    int m_idle  = 0;
    bit m_valid = 0;
    bit m_err   = 0;

    delta_decoder #(
        .WIDTH  (WIDTH),
        .LEAK_W (LEAK_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .spike       (spike),
        .step        (step),
        .load        (load),
        .load_value  (load_value),
        .leak_period (leak_period),
        .value       (value),
        .value_valid (value_valid),
        .sat_hi      (sat_hi),
        .sat_lo      (sat_lo),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: one call per rising edge, using the inputs sampled at that edge.
    task automatic model_step();
        int period;
        period = int'(leak_period);
        if (!rst_n) begin
            m_value = 0; m_base = 0; m_idle = 0; m_valid = 0; m_err = 0;
            return;
        end
        if (in_valid && spike == 2'b11) m_err = 1;
        m_valid = 0;
        if (load) begin
            m_value = int'(load_value);
            m_base  = m_value;
            m_idle  = 0;
            m_valid = 1;
        end else if (in_valid && spike == 2'b01) begin
            m_value = (m_value + int'(step) > MAXV) ? MAXV : m_value + int'(step);
            m_idle  = 0;
            m_valid = 1;
        end else if (in_valid && spike == 2'b10) begin
            m_value = (m_value - int'(step) < 0) ? 0 : m_value - int'(step);
            m_idle  = 0;
            m_valid = 1;
        end else if (period == 0) begin
            m_idle = 0;
        end else if (m_idle >= period - 1) begin
            m_idle = 0;
            if (m_value != m_base) begin
                m_value = (m_value > m_base) ? m_value - 1 : m_value + 1;
                m_valid = 1;
            end
        end else begin
            m_idle = (m_idle + 1 > IDLE_SAT) ? IDLE_SAT : m_idle + 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare just after it.
    task automatic apply(input bit r, input bit v, input logic [1:0] s, input int st,
                         input bit ld, input int lv, input int lp, input string tag);
        @(negedge clk);
        rst_n       = r;
        in_valid    = v;
        spike       = s;
        step        = WIDTH'(st);
        load        = ld;
        load_value  = WIDTH'(lv);
        leak_period = LEAK_W'(lp);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".value"},  32'(value),       32'(m_value));
        check({tag, ".valid"},  32'(value_valid), 32'(m_valid));
        check({tag, ".sat_hi"}, 32'(sat_hi),      32'(m_value == MAXV));
        check({tag, ".sat_lo"}, 32'(sat_lo),      32'(m_value == 0));
        check({tag, ".err"},    32'(err),         32'(m_err));
    endtask

    initial begin
        // 1: reset held with ON spikes present.
        for (int i = 0; i < 3; i++) apply(0, 1, 2'b01, 3, 0, 0, 0, "t1");
        check("t1.reset_value", 32'(value), 0);
        check("t1.reset_sat_lo", 32'(sat_lo), 1);

        // 2: step 3 ramp, then saturation at 15.
        for (int i = 0; i < 4; i++) begin
            apply(1, 1, 2'b01, 3, 0, 0, 0, "t2");
            check("t2.ramp", 32'(value), 32'(3 * (i + 1)));
        end
        apply(1, 1, 2'b01, 3, 0, 0, 0, "t2");
        apply(1, 1, 2'b01, 3, 0, 0, 0, "t2");
        check("t2.sat_value", 32'(value), 15);
        check("t2.sat_hi", 32'(sat_hi), 1);

        // 3: OFF clamps at 0, illegal spike sets sticky err.
        apply(1, 0, 2'b00, 0, 1, 2, 0, "t3");
        apply(1, 1, 2'b10, 5, 0, 0, 0, "t3");
        check("t3.clamp_lo", 32'(value), 0);
        apply(1, 1, 2'b11, 5, 0, 0, 0, "t3");
        apply(1, 1, 2'b00, 5, 0, 0, 0, "t3");
        check("t3.err_sticky", 32'(err), 1);
        apply(1, 1, 2'b01, 0, 0, 0, 0, "t3.step0");

        // 4: load 8, ON to 12, leak back down to the baseline and stop there.
        apply(1, 0, 2'b00, 0, 1, 8, 0, "t4");
        apply(1, 1, 2'b01, 4, 0, 0, 3, "t4");
        for (int i = 0; i < 3; i++) apply(1, 0, 2'b00, 4, 0, 0, 3, "t4");
        check("t4.first_leak", 32'(value), 11);
        for (int i = 0; i < 12; i++) apply(1, 0, 2'b00, 4, 0, 0, 3, "t4");
        check("t4.at_baseline", 32'(value), 8);

        // 5: ON on the expiry cycle wins; idle count restarts.
        apply(1, 1, 2'b01, 1, 0, 0, 2, "t5");
        apply(1, 0, 2'b00, 1, 0, 0, 2, "t5");
        apply(1, 1, 2'b01, 1, 0, 0, 2, "t5");
        check("t5.spike_wins", 32'(value), 10);
        apply(1, 0, 2'b00, 1, 0, 0, 2, "t5");
        check("t5.restart", 32'(value), 10);
        apply(1, 0, 2'b00, 1, 0, 0, 2, "t5");
        check("t5.leak", 32'(value), 9);

        // 6: reset mid-stream with load asserted; baseline must be 0 afterwards.
        apply(0, 1, 2'b01, 3, 1, 5, 1, "t6");
        check("t6.reset_value", 32'(value), 0);
        apply(1, 1, 2'b01, 3, 0, 0, 1, "t6");
        apply(1, 0, 2'b00, 3, 0, 0, 1, "t6");
        check("t6.leak_to_zero", 32'(value), 2);

        // Randomized traffic.
        begin
            int lp;
            lp = 3;
            for (int n = 0; n < 2000; n++) begin
                if (n % 64 == 0) begin
                    case ($urandom_range(0, 4))
                        0: lp = 0;
                        1: lp = 1;
                        2: lp = 2;
                        3: lp = 3;
                        default: lp = 6;
                    endcase
                end
                apply($urandom_range(0, 255) != 0,
                      $urandom_range(0, 3) != 0,
                      2'($urandom_range(0, 3)),
                      int'($urandom_range(0, MAXV)),
                      $urandom_range(0, 31) == 0,
                      int'($urandom_range(0, MAXV)),
                      lp, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
